data_bank_arbiter: RTL and testbench

- Shares one data-bank request channel between N_REQ requesters. Each request carries noop, way, set, beat and mask fields.
- Round-robin arbitration, with burst locking: a requester keeps ownership until the final beat of its burst.
- Winning requests go into a 1-entry output register, which drives the single-entry request queue in front of the banked data array.

---
 rtl/data_bank_arbiter.sv | 162 ++++++++++++++++
 tb/tb_data_bank_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/data_bank_arbiter.sv
// Round-robin arbiter sharing one data-bank request channel between N_REQ requesters,
// with burst locking and a single-entry registered output stage.
module data_bank_arbiter #(
  parameter int N_REQ     = 3,
  parameter int WAY_W     = 3,
  parameter int SET_W     = 10,
  parameter int BEAT_W    = 3,
  parameter int LAST_BEAT = 7,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        io_in_valid,
  output logic [N_REQ-1:0]        io_in_ready,
  input  logic [N_REQ-1:0]        io_in_bits_noop,
  input  logic [N_REQ*WAY_W-1:0]  io_in_bits_way,
  input  logic [N_REQ*SET_W-1:0]  io_in_bits_set,
  input  logic [N_REQ*BEAT_W-1:0] io_in_bits_beat,
  input  logic [N_REQ-1:0]        io_in_bits_mask,
  input  logic                    io_out_ready,
  output logic                    io_out_valid,
  output logic                    io_out_bits_noop,
  output logic [WAY_W-1:0]        io_out_bits_way,
  output logic [SET_W-1:0]        io_out_bits_set,
  output logic [BEAT_W-1:0]       io_out_bits_beat,
  output logic                    io_out_bits_mask,
  output logic [ID_W-1:0]         io_out_id,
  output logic                    io_busy
);

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_t;

  lock_state_t       lock_state_q, lock_state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_full_q, out_full_d;
  logic              out_noop_q, out_noop_d;
  logic [WAY_W-1:0]  out_way_q, out_way_d;
  logic [SET_W-1:0]  out_set_q, out_set_d;
  logic [BEAT_W-1:0] out_beat_q, out_beat_d;
  logic              out_mask_q, out_mask_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;

  logic              slot_ready;
  logic              has_grant;
  logic              found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   scan_idx;
  logic [N_REQ-1:0]  grant;
  logic              fire;
  logic              win_noop;
  logic [WAY_W-1:0]  win_way;
  logic [SET_W-1:0]  win_set;
  logic [BEAT_W-1:0] win_beat;
  logic              win_mask;

  // Grant selection: locked owner wins unconditionally, otherwise first valid from rr_ptr.
  always_comb begin
    has_grant = 1'b0;
    found     = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    grant     = '0;
    if (lock_state_q == ST_LOCKED) begin
      has_grant = 1'b1;
      win_id    = owner_q;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        scan_idx = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
        if (!found && io_in_valid[scan_idx]) begin
          found  = 1'b1;
          win_id = scan_idx;
        end
      end
      has_grant = found;
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      grant[i] = has_grant && (win_id == ID_W'(i));
    end
  end

  assign slot_ready  = io_out_ready | ~out_full_q;
  // Held low while reset is asserted so no requester sees an accept during reset.
  assign io_in_ready = grant & {N_REQ{slot_ready & reset}};
  assign fire        = |(io_in_valid & io_in_ready);

  assign win_noop = io_in_bits_noop[win_id];
  assign win_way  = io_in_bits_way[win_id*WAY_W +: WAY_W];
  assign win_set  = io_in_bits_set[win_id*SET_W +: SET_W];
  assign win_beat = io_in_bits_beat[win_id*BEAT_W +: BEAT_W];
  assign win_mask = io_in_bits_mask[win_id];

  always_comb begin
    lock_state_d = lock_state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    out_full_d   = out_full_q;
    out_noop_d   = out_noop_q;
    out_way_d    = out_way_q;
    out_set_d    = out_set_q;
    out_beat_d   = out_beat_q;
    out_mask_d   = out_mask_q;
    out_id_d     = out_id_q;
    if (fire) begin
      out_full_d = 1'b1;
      out_noop_d = win_noop;
      out_way_d  = win_way;
      out_set_d  = win_set;
      out_beat_d = win_beat;
      out_mask_d = win_mask;
      out_id_d   = win_id;
      rr_ptr_d   = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
      if (win_noop || (win_beat == BEAT_W'(LAST_BEAT))) begin
        lock_state_d = ST_OPEN;
      end else begin
        lock_state_d = ST_LOCKED;
        owner_d      = win_id;
      end
    end else if (io_out_ready && out_full_q) begin
      out_full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_state_q <= ST_OPEN;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      out_full_q   <= 1'b0;
      out_noop_q   <= 1'b0;
      out_way_q    <= '0;
      out_set_q    <= '0;
      out_beat_q   <= '0;
      out_mask_q   <= 1'b0;
      out_id_q     <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      out_full_q   <= out_full_d;
      out_noop_q   <= out_noop_d;
      out_way_q    <= out_way_d;
      out_set_q    <= out_set_d;
      out_beat_q   <= out_beat_d;
      out_mask_q   <= out_mask_d;
      out_id_q     <= out_id_d;
    end
  end

  assign io_out_valid     = out_full_q;
  assign io_out_bits_noop = out_noop_q;
  assign io_out_bits_way  = out_way_q;
  assign io_out_bits_set  = out_set_q;
  assign io_out_bits_beat = out_beat_q;
  assign io_out_bits_mask = out_mask_q;
  assign io_out_id        = out_id_q;
  assign io_busy          = (lock_state_q == ST_LOCKED);

endmodule

// File: tb/tb_data_bank_arbiter.sv
// Directed self-checking bench for data_bank_arbiter (N_REQ=3, LAST_BEAT=7).
module tb_data_bank_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  io_in_valid;
  logic [2:0]  io_in_ready;
  logic [2:0]  io_in_bits_noop;
  logic [8:0]  io_in_bits_way;
  logic [29:0] io_in_bits_set;
  logic [8:0]  io_in_bits_beat;
  logic [2:0]  io_in_bits_mask;
  logic        io_out_ready;
  logic        io_out_valid;
  logic        io_out_bits_noop;
  logic [2:0]  io_out_bits_way;
  logic [9:0]  io_out_bits_set;
  logic [2:0]  io_out_bits_beat;
  logic        io_out_bits_mask;
  logic [1:0]  io_out_id;
  logic        io_busy;

  int checks = 0;
  int errors = 0;

  data_bank_arbiter #(
    .N_REQ(3), .WAY_W(3), .SET_W(10), .BEAT_W(3), .LAST_BEAT(7)
  ) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_noop(io_in_bits_noop), .io_in_bits_way(io_in_bits_way),
    .io_in_bits_set(io_in_bits_set), .io_in_bits_beat(io_in_bits_beat),
    .io_in_bits_mask(io_in_bits_mask), .io_out_ready(io_out_ready),
    .io_out_valid(io_out_valid), .io_out_bits_noop(io_out_bits_noop),
    .io_out_bits_way(io_out_bits_way), .io_out_bits_set(io_out_bits_set),
    .io_out_bits_beat(io_out_bits_beat), .io_out_bits_mask(io_out_bits_mask),
    .io_out_id(io_out_id), .io_busy(io_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int i, input logic vld, input logic nop, input int b,
                       input int w, input int s, input logic m);
    io_in_valid[i]          = vld;
    io_in_bits_noop[i]      = nop;
    io_in_bits_beat[i*3 +: 3]  = 3'(b);
    io_in_bits_way[i*3 +: 3]   = 3'(w);
    io_in_bits_set[i*10 +: 10] = 10'(s);
    io_in_bits_mask[i]      = m;
  endtask

  initial begin
    reset           = 1'b1;
    io_in_valid     = '0;
    io_in_bits_noop = '0;
    io_in_bits_way  = '0;
    io_in_bits_set  = '0;
    io_in_bits_beat = '0;
    io_in_bits_mask = '0;
    io_out_ready    = 1'b0;
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(io_out_valid), 0);
    chk("rst_busy", 32'(io_busy), 0);
    reset = 1'b1;

    // Idle after reset release
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_valid", 32'(io_out_valid), 0);
      chk("idle_ready", 32'(io_in_ready), 0);
      chk("idle_busy", 32'(io_busy), 0);
    end

    // Single last-beat request from req1
    io_out_ready = 1'b1;
    drive(1, 1'b1, 1'b0, 7, 5, 'h2A5, 1'b1);
    #1 chk("single_ready", 32'(io_in_ready), 32'b010);
    tick();
    drive(1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("single_valid", 32'(io_out_valid), 1);
    chk("single_id", 32'(io_out_id), 1);
    chk("single_beat", 32'(io_out_bits_beat), 7);
    chk("single_way", 32'(io_out_bits_way), 5);
    chk("single_set", 32'(io_out_bits_set), 'h2A5);
    chk("single_mask", 32'(io_out_bits_mask), 1);
    chk("single_busy", 32'(io_busy), 0);
    // rr_ptr should now be 2: with req0 and req2 valid, req2 is offered
    drive(0, 1'b1, 1'b1, 0, 0, 0, 1'b0);
    drive(2, 1'b1, 1'b1, 0, 0, 0, 1'b0);
    #1 chk("rr_after_1", 32'(io_in_ready), 32'b100);
    drive(0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    tick();
    drive(2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("req2_id", 32'(io_out_id), 2);

    // All three valid noop: rr_ptr=0 so order 0,1,2,0
    drive(0, 1'b1, 1'b1, 0, 1, 'h010, 1'b0);
    drive(1, 1'b1, 1'b1, 0, 2, 'h020, 1'b0);
    drive(2, 1'b1, 1'b1, 0, 3, 'h030, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1 chk("rr_ready", 32'(io_in_ready), 32'(1 << (c % 3)));
      tick();
      chk("rr_id", 32'(io_out_id), 32'(c % 3));
      chk("rr_valid", 32'(io_out_valid), 1);
      chk("rr_set", 32'(io_out_bits_set), 32'('h010 * ((c % 3) + 1)));
    end
    // rr_ptr=1; fire req2 alone to bring rr_ptr back to 0
    drive(0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    drive(1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    tick();
    drive(2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("rr_tail_id", 32'(io_out_id), 2);
    tick();
    chk("drain_valid", 32'(io_out_valid), 0);

    // Req0 burst 0..7 with req2 valid throughout; owner drops valid once after beat 3
    drive(2, 1'b1, 1'b1, 0, 6, 'h3FF, 1'b0);
    for (int b = 0; b < 8; b++) begin
      drive(0, 1'b1, 1'b0, b, 4, 'h100 + b, 1'b1);
      #1 chk("burst_ready", 32'(io_in_ready), 32'b001);
      tick();
      chk("burst_id", 32'(io_out_id), 0);
      chk("burst_beat", 32'(io_out_bits_beat), 32'(b));
      chk("burst_busy", 32'(io_busy), (b == 7) ? 0 : 1);
      if (b == 3) begin
        drive(0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        #1 chk("gap_ready", 32'(io_in_ready), 32'b001);
        tick();
        chk("gap_valid", 32'(io_out_valid), 0);
        chk("gap_busy", 32'(io_busy), 1);
      end
    end
    drive(0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    #1 chk("post_burst_ready", 32'(io_in_ready), 32'b100);
    tick();
    drive(2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("post_burst_id", 32'(io_out_id), 2);
    chk("post_burst_set", 32'(io_out_bits_set), 'h3FF);
    tick();

    // Backpressure (rr_ptr=0)
    io_out_ready = 1'b0;
    drive(0, 1'b1, 1'b1, 0, 3, 'h111, 1'b0);
    #1 chk("bp_ready0", 32'(io_in_ready), 32'b001);
    tick();
    drive(0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    drive(1, 1'b1, 1'b1, 2, 6, 'h222, 1'b1);
    chk("bp_valid", 32'(io_out_valid), 1);
    chk("bp_id0", 32'(io_out_id), 0);
    #1 chk("bp_stall_ready", 32'(io_in_ready), 32'b000);
    tick();
    chk("bp_hold_set", 32'(io_out_bits_set), 'h111);
    chk("bp_hold_valid", 32'(io_out_valid), 1);
    io_out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(io_in_ready), 32'b010);
    tick();
    drive(1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("bp_swap_valid", 32'(io_out_valid), 1);
    chk("bp_swap_id", 32'(io_out_id), 1);
    chk("bp_swap_set", 32'(io_out_bits_set), 'h222);
    chk("bp_swap_way", 32'(io_out_bits_way), 6);
    tick();
    chk("bp_drain", 32'(io_out_valid), 0);

    // Reset mid-burst (rr_ptr=2, req0 alone wins)
    for (int b = 0; b < 4; b++) begin
      drive(0, 1'b1, 1'b0, b, 1, 'h050, 1'b0);
      tick();
    end
    chk("mid_busy", 32'(io_busy), 1);
    chk("mid_valid", 32'(io_out_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(io_busy), 0);
    chk("arst_valid", 32'(io_out_valid), 0);
    chk("arst_ready", 32'(io_in_ready), 32'b000);
    tick();
    drive(0, 1'b1, 1'b1, 0, 2, 'h0AA, 1'b0);
    drive(2, 1'b1, 1'b1, 0, 7, 'h0BB, 1'b0);
    reset = 1'b1;
    #1 chk("post_rst_ready", 32'(io_in_ready), 32'b001);
    tick();
    chk("post_rst_id", 32'(io_out_id), 0);
    chk("post_rst_set", 32'(io_out_bits_set), 'h0AA);
    drive(0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    drive(2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
